// File: rtl/aes_ctr_sequencer.sv
// aes_ctr_sequencer: CTR-mode controller wrapped around the iterative AES-256 core.
// It owns every core strobe, keeps the 128-bit counter block, encrypts one counter
// block per accepted input beat and streams out s_data XOR keystream.
module aes_ctr_sequencer #(
    parameter int CTR_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [255:0] cfg_key,
    input  logic         cfg_key_load,
    input  logic [127:0] cfg_iv,
    input  logic         cfg_iv_load,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [127:0] s_data,
    input  logic         s_last,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [127:0] m_data,
    output logic         m_last,
    output logic [255:0] core_key,
    output logic         core_key_valid,
    output logic [127:0] core_plaintext,
    output logic         core_encrypt_start,
    output logic         core_clear,
    input  logic         core_ready,
    input  logic         core_done,
    input  logic [127:0] core_ciphertext,
    output logic         key_loaded,
    output logic         iv_loaded,
    output logic         ctr_wrap,
    output logic         err_timeout
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] WAIT_LIMIT = TW'(TIMEOUT_CYCLES - 1);

    // Only the low CTR_WIDTH bits count; the rest of the block is a fixed nonce.
    localparam logic [127:0] LOW_MASK = (128'd1 << CTR_WIDTH) - 128'd1;

    typedef enum logic [2:0] {
        IDLE,
        KEY_WAIT,
        STANDBY,
        ISSUE,
        WAIT_DONE,
        OUTPUT,
        ERROR
    } state_t;

    state_t         state;
    logic [127:0]   counter;
    logic [127:0]   beat_data;
    logic           beat_last;
    logic [TW-1:0]  wait_cnt;

    logic [127:0]   ctr_plus;
    logic [127:0]   ctr_inc;
    logic           ctr_wrapped;
    logic           key_take;
    logic           iv_take;
    logic           accept;

    assign ctr_plus    = counter + 128'd1;
    assign ctr_inc     = (counter & ~LOW_MASK) | (ctr_plus & LOW_MASK);
    assign ctr_wrapped = (ctr_plus & LOW_MASK) == 128'd0;

    assign key_take = cfg_key_load & ((state == IDLE) | (state == STANDBY));
    assign iv_take  = cfg_iv_load & ((state == IDLE) | (state == KEY_WAIT) | (state == STANDBY));

    // A pending key load wins over an input beat so no block is issued with a stale key.
    assign s_ready = (state == STANDBY) & key_loaded & iv_loaded & core_ready & ~cfg_key_load;
    assign accept  = s_valid & s_ready;

    // The counter register drives the core directly, so the block is ready before the start pulse.
    assign core_plaintext = counter;

    // Control FSM: key load, per-beat encrypt/clear sequencing, output hold and watchdog.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state              <= IDLE;
            counter            <= '0;
            beat_data          <= '0;
            beat_last          <= 1'b0;
            wait_cnt           <= '0;
            m_valid            <= 1'b0;
            m_data             <= '0;
            m_last             <= 1'b0;
            core_key           <= '0;
            core_key_valid     <= 1'b0;
            core_encrypt_start <= 1'b0;
            core_clear         <= 1'b0;
            key_loaded         <= 1'b0;
            iv_loaded          <= 1'b0;
            ctr_wrap           <= 1'b0;
            err_timeout        <= 1'b0;
        end else begin
            core_key_valid     <= 1'b0;
            core_encrypt_start <= 1'b0;
            core_clear         <= 1'b0;

            if (key_take) begin
                core_key       <= cfg_key;
                core_key_valid <= 1'b1;
                key_loaded     <= 1'b0;
            end

            if (iv_take) begin
                counter   <= cfg_iv;
                iv_loaded <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (key_take) begin
                        wait_cnt <= '0;
                        state    <= KEY_WAIT;
                    end
                end

                KEY_WAIT: begin
                    // The first KEY_WAIT cycle still sees core_ready from before the
                    // core sampled key_valid, so it is not trusted.
                    if (core_ready && (wait_cnt != '0)) begin
                        key_loaded <= 1'b1;
                        state      <= STANDBY;
                    end else if (wait_cnt == WAIT_LIMIT) begin
                        err_timeout <= 1'b1;
                        key_loaded  <= 1'b0;
                        state       <= ERROR;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end

                STANDBY: begin
                    if (key_take) begin
                        wait_cnt <= '0;
                        state    <= KEY_WAIT;
                    end else if (accept) begin
                        beat_data          <= s_data;
                        beat_last          <= s_last;
                        core_encrypt_start <= 1'b1;
                        state              <= ISSUE;
                    end
                end

                ISSUE: begin
                    wait_cnt <= '0;
                    state    <= WAIT_DONE;
                end

                WAIT_DONE: begin
                    if (core_done) begin
                        m_data     <= beat_data ^ core_ciphertext;
                        m_last     <= beat_last;
                        m_valid    <= 1'b1;
                        core_clear <= 1'b1;
                        counter    <= ctr_inc;
                        if (ctr_wrapped) begin
                            ctr_wrap  <= 1'b1;
                            iv_loaded <= 1'b0;
                        end
                        state <= OUTPUT;
                    end else if (wait_cnt == WAIT_LIMIT) begin
                        err_timeout <= 1'b1;
                        key_loaded  <= 1'b0;
                        state       <= ERROR;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end

                OUTPUT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        if (m_last) begin
                            iv_loaded <= 1'b0;
                        end
                        state <= STANDBY;
                    end
                end

                ERROR: begin
                    state <= ERROR;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_ctr_sequencer.sv
// tb_aes_ctr_sequencer: directed bench for aes_ctr_sequencer with a behavioural
// stand-in for aes_core that returns SP800-38A F.5.5 keystream blocks.
module tb_aes_ctr_sequencer;

    localparam int TIMEOUT = 255;

    localparam logic [255:0] KEY1 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [255:0] KEY2 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    localparam logic [127:0] CB1 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [127:0] CB2 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00;
    localparam logic [127:0] CB3 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff01;
    localparam logic [127:0] CB4 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff02;
    localparam logic [127:0] CB5 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff03;

    localparam logic [127:0] PT [0:3] = '{
        128'h6bc1bee22e409f96e93d7e117393172a,
        128'hae2d8a571e03ac9c9eb76fac45af8e51,
        128'h30c81c46a35ce411e5fbc1191a0a52ef,
        128'hf69f2445df4f9b17ad2b417be66c3710
    };
    localparam logic [127:0] CT [0:3] = '{
        128'h601ec313775789a5b7a7f504bbf3d228,
        128'hf443e3ca4d62b59aca84e990cacaf5c5,
        128'h2b0930daa23de94ce87017ba2d84988d,
        128'hdfc9c58db67aada613c2dd08457941a6
    };

    localparam logic [127:0] IV_WRAP  = 128'h00112233445566778899aabbffffffff;
    localparam logic [127:0] WRAP_OUT = 128'hffeeddccbbaa998877665544_00000000;
    localparam logic [127:0] WRAP_CTR = 128'h00112233445566778899aabb_00000000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [255:0] cfg_key;
    logic         cfg_key_load;
    logic [127:0] cfg_iv;
    logic         cfg_iv_load;
    logic         s_valid;
    logic         s_ready;
    logic [127:0] s_data;
    logic         s_last;
    logic         m_valid;
    logic         m_ready;
    logic [127:0] m_data;
    logic         m_last;
    logic [255:0] core_key;
    logic         core_key_valid;
    logic [127:0] core_plaintext;
    logic         core_encrypt_start;
    logic         core_clear;
    logic         core_ready;
    logic         core_done;
    logic [127:0] core_ciphertext;
    logic         key_loaded;
    logic         iv_loaded;
    logic         ctr_wrap;
    logic         err_timeout;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;
    int startCount = 0;
    int hsCount    = 0;

    logic         core_dead;
    logic         key_busy;
    logic [5:0]   key_cnt;
    logic         enc_busy;
    logic [4:0]   enc_cnt;
    logic [127:0] enc_pt;

    aes_ctr_sequencer #(
        .CTR_WIDTH(32),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cfg_key(cfg_key),
        .cfg_key_load(cfg_key_load),
        .cfg_iv(cfg_iv),
        .cfg_iv_load(cfg_iv_load),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data(s_data),
        .s_last(s_last),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data(m_data),
        .m_last(m_last),
        .core_key(core_key),
        .core_key_valid(core_key_valid),
        .core_plaintext(core_plaintext),
        .core_encrypt_start(core_encrypt_start),
        .core_clear(core_clear),
        .core_ready(core_ready),
        .core_done(core_done),
        .core_ciphertext(core_ciphertext),
        .key_loaded(key_loaded),
        .iv_loaded(iv_loaded),
        .ctr_wrap(ctr_wrap),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Known F.5.5 keystream blocks; any other counter block gets its bitwise inverse.
    function automatic logic [127:0] fakeAes(input logic [127:0] pt);
        case (pt)
            CB1:     return 128'h0bdf7df1591716335e9a8b15c860c502;
            CB2:     return 128'h5a6e699d536119065433863c8f657b94;
            CB3:     return 128'h1bc12c9c01610d5d0d8bd6a3378eca62;
            CB4:     return 128'h2956e1c8693536b1bee99c73a31576b6;
            default: return ~pt;
        endcase
    endfunction

    // Core stand-in: 53-cycle key expansion, done 14 cycles after sampling start, ready again after clear.
    always @(posedge clk) begin
        core_done <= 1'b0;
        if (!rst_n) begin
            core_ready      <= 1'b0;
            core_ciphertext <= '0;
            key_busy        <= 1'b0;
            key_cnt         <= '0;
            enc_busy        <= 1'b0;
            enc_cnt         <= '0;
            enc_pt          <= '0;
        end else if (core_key_valid) begin
            core_ready <= 1'b0;
            key_busy   <= 1'b1;
            key_cnt    <= '0;
            enc_busy   <= 1'b0;
        end else if (key_busy) begin
            if (key_cnt == 6'd52) begin
                key_busy   <= 1'b0;
                core_ready <= 1'b1;
            end else begin
                key_cnt <= key_cnt + 6'd1;
            end
        end else if (core_encrypt_start) begin
            core_ready <= 1'b0;
            enc_busy   <= 1'b1;
            enc_cnt    <= '0;
            enc_pt     <= core_plaintext;
        end else if (enc_busy) begin
            if (enc_cnt == 5'd13) begin
                enc_busy <= 1'b0;
                if (!core_dead) begin
                    core_done       <= 1'b1;
                    core_ciphertext <= fakeAes(enc_pt);
                end
            end else begin
                enc_cnt <= enc_cnt + 5'd1;
            end
        end else if (core_clear) begin
            core_ready <= 1'b1;
        end
    end

    // Event counters for encrypt starts and output handshakes.
    always @(posedge clk) begin
        if (core_encrypt_start) startCount <= startCount + 1;
        if (m_valid && m_ready) hsCount <= hsCount + 1;
    end

    task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Waits for s_ready, presents one beat for a single accepting edge, checks the start pulse.
    task automatic applyStimulus(input logic [127:0] data, input logic last);
        int cnt;
        cnt = 0;
        while (!s_ready && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("s_ready_before_beat", 256'(s_ready), 256'(1));
        s_valid = 1'b1;
        s_data  = data;
        s_last  = last;
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        checkOutput("encrypt_start_pulse", 256'(core_encrypt_start), 256'(1));
    endtask

    // Counts edges from the accept edge until m_valid is seen.
    task automatic waitOutput();
        int cnt;
        cnt = 0;
        while (!m_valid && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("accept_to_m_valid_latency", 256'(cnt), 256'(16));
    endtask

    task automatic consumeOutput();
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        checkOutput("m_valid_after_handshake", 256'(m_valid), 256'(0));
    endtask

    task automatic loadIv(input logic [127:0] iv);
        cfg_iv      = iv;
        cfg_iv_load = 1'b1;
        @(negedge clk);
        cfg_iv_load = 1'b0;
    endtask

    initial begin
        int cnt;
        int savedStarts;
        int savedHs;
        logic stable;

        rst_n        = 1'b0;
        cfg_key      = '0;
        cfg_key_load = 1'b0;
        cfg_iv       = '0;
        cfg_iv_load  = 1'b0;
        s_valid      = 1'b0;
        s_data       = '0;
        s_last       = 1'b0;
        m_ready      = 1'b0;
        core_dead    = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] reset state");
        checkOutput("reset_m_valid", 256'(m_valid), 256'(0));
        checkOutput("reset_s_ready", 256'(s_ready), 256'(0));
        checkOutput("reset_key_loaded", 256'(key_loaded), 256'(0));
        checkOutput("reset_iv_loaded", 256'(iv_loaded), 256'(0));
        checkOutput("reset_counter", 256'(core_plaintext), 256'(0));
        checkOutput("reset_err_timeout", 256'(err_timeout), 256'(0));
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] key and iv loaded in the same cycle");
        cfg_key      = KEY1;
        cfg_key_load = 1'b1;
        cfg_iv       = CB1;
        cfg_iv_load  = 1'b1;
        @(negedge clk);
        cfg_key_load = 1'b0;
        cfg_iv_load  = 1'b0;
        checkOutput("key_valid_pulse", 256'(core_key_valid), 256'(1));
        checkOutput("core_key_latched", core_key, KEY1);
        checkOutput("iv_loaded_set", 256'(iv_loaded), 256'(1));
        checkOutput("counter_from_iv", 256'(core_plaintext), 256'(CB1));
        @(negedge clk);
        checkOutput("key_valid_one_cycle", 256'(core_key_valid), 256'(0));
        cnt = 0;
        while (!key_loaded && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("key_loaded_rise", 256'(key_loaded), 256'(1));

        $display("[TB] four-beat F.5.5 message");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(PT[i], i == 3);
            waitOutput();
            checkOutput("f55_m_data", 256'(m_data), 256'(CT[i]));
            checkOutput("f55_m_last", 256'(m_last), 256'(i == 3));
            consumeOutput();
        end
        checkOutput("iv_cleared_after_last", 256'(iv_loaded), 256'(0));
        repeat (3) @(negedge clk);
        checkOutput("s_ready_low_after_last", 256'(s_ready), 256'(0));
        checkOutput("counter_after_four", 256'(core_plaintext), 256'(CB5));

        $display("[TB] output held under back-pressure");
        loadIv(CB1);
        applyStimulus(PT[0], 1'b1);
        waitOutput();
        savedStarts = startCount;
        stable = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (m_data !== CT[0] || m_valid !== 1'b1 || s_ready !== 1'b0) stable = 1'b0;
        end
        checkOutput("hold_output_stable", 256'(stable), 256'(1));
        checkOutput("hold_no_second_start", 256'(startCount), 256'(savedStarts));
        savedHs = hsCount;
        consumeOutput();
        repeat (3) @(negedge clk);
        checkOutput("hold_single_handshake", 256'(hsCount), 256'(savedHs + 1));

        $display("[TB] counter wrap");
        loadIv(IV_WRAP);
        applyStimulus(128'd0, 1'b0);
        waitOutput();
        checkOutput("wrap_m_data", 256'(m_data), 256'(WRAP_OUT));
        checkOutput("wrap_flag", 256'(ctr_wrap), 256'(1));
        checkOutput("wrap_iv_cleared", 256'(iv_loaded), 256'(0));
        checkOutput("wrap_counter", 256'(core_plaintext), 256'(WRAP_CTR));
        consumeOutput();
        repeat (3) @(negedge clk);
        checkOutput("wrap_s_ready_low", 256'(s_ready), 256'(0));
        loadIv(CB1);
        checkOutput("wrap_sticky_over_iv_load", 256'(ctr_wrap), 256'(1));
        checkOutput("iv_reloaded", 256'(iv_loaded), 256'(1));

        $display("[TB] key reload races an input beat");
        cnt = 0;
        while (!s_ready && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("reload_s_ready_before", 256'(s_ready), 256'(1));
        savedStarts  = startCount;
        cfg_key      = KEY2;
        cfg_key_load = 1'b1;
        s_valid      = 1'b1;
        s_data       = PT[0];
        #1;
        checkOutput("reload_s_ready_masked", 256'(s_ready), 256'(0));
        @(negedge clk);
        cfg_key_load = 1'b0;
        s_valid      = 1'b0;
        checkOutput("reload_key_valid", 256'(core_key_valid), 256'(1));
        checkOutput("reload_core_key", core_key, KEY2);
        checkOutput("reload_key_loaded_drop", 256'(key_loaded), 256'(0));
        checkOutput("reload_no_start", 256'(core_encrypt_start), 256'(0));
        cnt = 0;
        while (!key_loaded && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("reload_key_loaded_rise", 256'(key_loaded), 256'(1));
        checkOutput("reload_no_accept", 256'(startCount), 256'(savedStarts));

        $display("[TB] core never finishes");
        core_dead = 1'b1;
        applyStimulus(PT[0], 1'b0);
        cnt = 0;
        while (!err_timeout && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("timeout_cycles_in_wait_done", 256'(cnt - 1), 256'(TIMEOUT));
        checkOutput("timeout_key_loaded_drop", 256'(key_loaded), 256'(0));
        checkOutput("timeout_m_valid_low", 256'(m_valid), 256'(0));
        cfg_key_load = 1'b1;
        @(negedge clk);
        cfg_key_load = 1'b0;
        checkOutput("error_ignores_key_load", 256'(core_key_valid), 256'(0));
        checkOutput("error_sticky", 256'(err_timeout), 256'(1));

        rst_n     = 1'b0;
        core_dead = 1'b0;
        @(negedge clk);
        checkOutput("reset_clears_error", 256'(err_timeout), 256'(0));
        checkOutput("reset_clears_wrap", 256'(ctr_wrap), 256'(0));
        checkOutput("reset_clears_iv", 256'(iv_loaded), 256'(0));
        checkOutput("reset_clears_counter", 256'(core_plaintext), 256'(0));
        checkOutput("reset_clears_key", core_key, 256'(0));
        rst_n = 1'b1;
        @(negedge clk);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
